// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V main controller: states, opcodes,
// immediate selects, ALU operation classes and ALU control codes.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10,
        StLui      = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_e;

    localparam logic [6:0] OpLw     = 7'b0000011;
    localparam logic [6:0] OpSw     = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmU = 3'b011;
    localparam logic [2:0] ImmJ = 3'b100;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    // R-type and unsupported opcodes carry no immediate; fall back to the I code.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OpSw:     return ImmS;
            OpBranch: return ImmB;
            OpLui:    return ImmU;
            OpJal:    return ImmJ;
            default:  return ImmI;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the operation class and instruction fields.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = AluAdd;
        if (alu_op == AluOpSub) begin
            alu_control = AluSub;
        end else if (alu_op == AluOpFunct) begin
            case (funct3)
                3'b000:  alu_control = (op5 & funct7b5) ? AluSub : AluAdd;
                3'b010:  alu_control = AluSlt;
                3'b110:  alu_control = AluOr;
                3'b111:  alu_control = AluAnd;
                default: alu_control = AluAdd;
            endcase
        end
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle RISC-V main controller: state register plus Moore-decoded datapath
// controls, with the branch PC enable combinational in the ALU zero flag.
module main_control_fsm
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    state_e  state_q;
    alu_op_e alu_op;
    logic    op_known;

    always_comb begin
        case (op)
            OpLw, OpSw, OpR, OpI, OpBranch, OpJal, OpLui: op_known = 1'b1;
            default:                                      op_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            case (state_q)
                StFetch:  state_q <= StDecode;
                StDecode: begin
                    case (op)
                        OpLw, OpSw: state_q <= StMemAdr;
                        OpR:        state_q <= StExecuteR;
                        OpI:        state_q <= StExecuteI;
                        OpBranch:   state_q <= StBranch;
                        OpJal:      state_q <= StJal;
                        OpLui:      state_q <= StLui;
                        default:    state_q <= StFetch;
                    endcase
                end
                StMemAdr:   state_q <= (op == OpLw) ? StMemRead : StMemWrite;
                StMemRead:  state_q <= StMemWb;
                StExecuteR: state_q <= StAluWb;
                StExecuteI: state_q <= StAluWb;
                StJal:      state_q <= StAluWb;
                StLui:      state_q <= StAluWb;
                default:    state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = AluOpAdd;
        illegal   = 1'b0;
        ImmSrc    = (state_q == StFetch) ? ImmI : imm_src_of(op);
        case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                illegal = ~op_known;
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StMemRead:  AdrSrc = 1'b1;
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            StMemWrite: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            StExecuteR: begin
                ALUSrcA = 2'b10;
                alu_op  = AluOpFunct;
            end
            StExecuteI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = AluOpFunct;
            end
            StAluWb:    RegWrite = 1'b1;
            StJal: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            StLui: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            StBranch: begin
                ALUSrcA = 2'b10;
                alu_op  = AluOpSub;
                PCWrite = ((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero);
            end
            default: ;
        endcase
        // Reset suppresses every side effect of the instruction being aborted.
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state_dbg = state_q;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench: per-instruction phase model compared every cycle, plus
// directed literal checks on latency, enables, branch, ALU decode and reset abort.
module tb_main_control_fsm;
    import rv_ctrl_pkg::*;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] imm;
        logic [2:0] aluc;
        logic       ill;
        logic [3:0] st;
    } out_t;

    typedef struct {
        int         cycles;
        int         regw;
        int         memw;
        int         ill;
        int         en;
        logic       brpc;
        logic [2:0] aluc;
        logic [3:0] first_st;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;
    logic [3:0] state_dbg;

    out_t act;
    out_t exp_o = '0;
    logic exp_valid = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    main_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, ALUControl, illegal, state_dbg};

    always @(negedge clk) begin
        cyc++;
        if (exp_valid) begin
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("FAIL cycle_compare cyc=%0d op=%b f3=%b actual=%h required=%h (st %0d/%0d)",
                         cyc, op, funct3, act, exp_o, act.st, exp_o.st);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, got, want);
        end
    endtask

    function automatic logic [2:0] imm_code(input logic [6:0] o);
        case (o)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b0110111: return 3'b011;
            7'b1101111: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    // What the ALU must compute for a register/immediate arithmetic instruction.
    function automatic logic [2:0] alu_funct(input logic [2:0] f3, input logic o5, input logic f7);
        case (f3)
            3'b000:  return (o5 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic out_t phase_out(input state_e ph, input logic [6:0] o, input logic [2:0] f3,
                                       input logic f7, input logic z);
        out_t e = '0;
        e.st = 4'(ph);
        if (ph != StFetch) e.imm = imm_code(o);
        case (ph)
            StFetch:    begin e.pcw = 1; e.irw = 1; e.sb = 2'b10; e.res = 2'b10; end
            StDecode:   begin
                e.sa = 2'b01; e.sb = 2'b01;
                e.ill = !(o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                    7'b1100011, 7'b1101111, 7'b0110111});
            end
            StMemAdr:   begin e.sa = 2'b10; e.sb = 2'b01; end
            StMemRead:  e.adr = 1;
            StMemWb:    begin e.res = 2'b01; e.regw = 1; end
            StMemWrite: begin e.adr = 1; e.memw = 1; end
            StExecuteR: begin e.sa = 2'b10; e.aluc = alu_funct(f3, o[5], f7); end
            StExecuteI: begin e.sa = 2'b10; e.sb = 2'b01; e.aluc = alu_funct(f3, o[5], f7); end
            StAluWb:    e.regw = 1;
            StJal:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
            StLui:      begin e.sa = 2'b11; e.sb = 2'b01; end
            StBranch:   begin
                e.sa = 2'b10; e.aluc = 3'b001;
                e.pcw = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
            end
            default: ;
        endcase
        return e;
    endfunction

    // zsel < 0 picks zero randomly each cycle; abort_at >= 0 asserts reset in that cycle.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zsel, input int abort_at, output obs_t ob);
        state_e seq[$];
        out_t   e;
        logic   z;
        case (o)
            7'b0000011: seq = '{StFetch, StDecode, StMemAdr, StMemRead, StMemWb};
            7'b0100011: seq = '{StFetch, StDecode, StMemAdr, StMemWrite};
            7'b0110011: seq = '{StFetch, StDecode, StExecuteR, StAluWb};
            7'b0010011: seq = '{StFetch, StDecode, StExecuteI, StAluWb};
            7'b1101111: seq = '{StFetch, StDecode, StJal, StAluWb};
            7'b0110111: seq = '{StFetch, StDecode, StLui, StAluWb};
            7'b1100011: seq = '{StFetch, StDecode, StBranch};
            default:    seq = '{StFetch, StDecode};
        endcase
        ob = '{cycles: 1, regw: 0, memw: 0, ill: 0, en: 0, brpc: 1'b0, aluc: 3'b0, first_st: 4'hf};
        foreach (seq[k]) begin
            @(posedge clk);
            #1;
            reset = (k == abort_at);
            if (k == 0) begin
                op = o; funct3 = f3; funct7b5 = f7;
            end
            z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            zero = z;
            e = phase_out(seq[k], o, f3, f7, z);
            if (reset) begin
                e.pcw = 0; e.irw = 0; e.memw = 0; e.regw = 0; e.ill = 0;
            end
            exp_o = e;
            exp_valid = 1'b1;
            @(negedge clk);
            if (k == 0) ob.first_st = state_dbg;
            if (k > 0 && state_dbg != 4'd0) ob.cycles++;
            if (k > 0 && (PCWrite || IRWrite || MemWrite || RegWrite)) ob.en++;
            ob.regw += int'(RegWrite);
            ob.memw += int'(MemWrite);
            ob.ill  += int'(illegal);
            if (seq[k] == StBranch) ob.brpc = PCWrite;
            if (seq[k] == StExecuteR || seq[k] == StExecuteI) ob.aluc = ALUControl;
            if (reset) break;
        end
    endtask

    initial begin
        obs_t   ob;
        logic [6:0] ops [8];
        logic [6:0] o;
        int     len, ab;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b0110111, 7'b1111111};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_o = phase_out(StFetch, 7'b0, 3'b0, 1'b0, 1'b0);
        exp_o.pcw = 0; exp_o.irw = 0;
        exp_valid = 1'b1;
        @(negedge clk);
        chk("reset_state_fetch", int'(state_dbg), 0);
        chk("reset_irwrite_low", int'(IRWrite), 0);

        run_instr(7'b0000011, 3'b010, 1'b0, -1, -1, ob);
        chk("lw_latency", ob.cycles, 5);
        chk("lw_regwrite_once", ob.regw, 1);

        run_instr(7'b0100011, 3'b010, 1'b0, -1, -1, ob);
        chk("sw_latency", ob.cycles, 4);
        chk("sw_memwrite_once", ob.memw, 1);
        chk("sw_no_regwrite", ob.regw, 0);

        run_instr(7'b1100011, 3'b000, 1'b0, 1, -1, ob);
        chk("beq_taken_pcwrite", int'(ob.brpc), 1);
        chk("branch_latency", ob.cycles, 3);
        run_instr(7'b1100011, 3'b000, 1'b0, 0, -1, ob);
        chk("beq_not_taken_pcwrite", int'(ob.brpc), 0);
        run_instr(7'b1100011, 3'b001, 1'b0, 0, -1, ob);
        chk("bne_taken_pcwrite", int'(ob.brpc), 1);

        run_instr(7'b0110011, 3'b000, 1'b1, -1, -1, ob);
        chk("rtype_sub_alucontrol", int'(ob.aluc), 1);
        run_instr(7'b0010011, 3'b000, 1'b1, -1, -1, ob);
        chk("addi_f7_alucontrol", int'(ob.aluc), 0);
        chk("addi_latency", ob.cycles, 4);

        run_instr(7'b1111111, 3'b000, 1'b0, -1, -1, ob);
        chk("illegal_pulse_count", ob.ill, 1);
        chk("illegal_latency", ob.cycles, 2);
        chk("illegal_no_enables", ob.en, 0);

        run_instr(7'b0000011, 3'b010, 1'b0, -1, 3, ob);
        chk("abort_memread_no_regwrite", ob.regw, 0);
        run_instr(7'b0110111, 3'b000, 1'b0, -1, -1, ob);
        chk("after_abort_first_fetch", int'(ob.first_st), 0);

        for (int n = 0; n < 400; n++) begin
            o = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 7'($urandom);
            case (o)
                7'b0000011:                         len = 5;
                7'b1100011:                         len = 3;
                7'b0100011, 7'b0110011, 7'b0010011,
                7'b1101111, 7'b0110111:             len = 4;
                default:                            len = 2;
            endcase
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_instr(o, 3'($urandom), 1'($urandom), -1, ab, ob);
        end

        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        reset = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 The block SHALL have no parameters; all encodings come from the shared package.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  7  instruction[6:0] from the instruction register.
REQ-005 funct3  input  3  instruction[14:12].
REQ-006 funct7b5  input  1  instruction[30].
REQ-007 zero  input  1  ALU zero flag, valid in the BRANCH state.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables/selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB  output  2 each  result/ALU operand mux selects.
REQ-010 ImmSrc  output  3  immediate-decoder select: I=000, S=001, B=010, U=011, J=100; 101-111 unused, never driven.
REQ-011 ALUControl  output  3  ADD=000, SUB=001, AND=010, OR=011, SLT=101.
REQ-012 illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-013 state_dbg  output  4  current state encoding, for debug only.

Function
REQ-014 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, LUI; the state register is the only sequential element.
REQ-015 FETCH SHALL assert IRWrite=1 and PCWrite=1, with AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10; FETCH->DECODE unconditionally.
REQ-016 DECODE SHALL set ALUSrcA=01, ALUSrcB=01, ALUOp=add (branch target precompute) and ImmSrc per op.
REQ-017 From DECODE: lw(0000011)/sw(0100011)->MEMADR; R(0110011)->EXECUTER; I-ALU(0010011)->EXECUTEI; branch(1100011)->BRANCH; jal(1101111)->JAL; lui(0110111)->LUI; any other op->FETCH with illegal=1 for that cycle.
REQ-018 MEMADR (ALUSrcA=10, ALUSrcB=01, ALUOp=add) SHALL go to MEMREAD if op=lw, and to MEMWRITE if op=sw.
REQ-019 The remaining transitions SHALL be: MEMREAD (AdrSrc=1, ResultSrc=00)->MEMWB; MEMWB (ResultSrc=01, RegWrite=1)->FETCH; MEMWRITE (AdrSrc=1, MemWrite=1)->FETCH.
REQ-020 EXECUTER (ALUSrcA=10, ALUSrcB=00, ALUOp=funct) and EXECUTEI (ALUSrcA=10, ALUSrcB=01, ALUOp=funct) SHALL both go to ALUWB; ALUWB (ResultSrc=00, RegWrite=1) SHALL go to FETCH.
REQ-021 JAL SHALL set ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1 and go to ALUWB.
REQ-022 LUI SHALL set ALUSrcB=01 and ImmSrc=011, pass the immediate through ALU add with ALUSrcA=11 (zero), and go to ALUWB.
REQ-023 BRANCH SHALL set ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00; PCWrite=(funct3==000 & zero)|(funct3==001 & ~zero), combinational in zero; BRANCH->FETCH.
REQ-024 ImmSrc SHALL hold the code for the current instruction type in DECODE and in all execute/memory states, and be 000 in FETCH.
REQ-025 ALU decoding SHALL be: ALUOp add->ADD; sub->SUB; funct: funct3 000->SUB if (op[5]&funct7b5) else ADD, 010->SLT, 110->OR, 111->AND, others->ADD.
REQ-026 All outputs not listed for a state SHALL be 0 in that state.
REQ-027 Instruction latency SHALL be: lw 5 cycles; sw, R, I, jal, lui 4 cycles; branch 3 cycles; illegal 2 cycles.

Reset
REQ-028 While reset=1, the state SHALL load FETCH on every edge and all enables (PCWrite, IRWrite, MemWrite, RegWrite) and illegal SHALL be forced to 0.
REQ-029 Reset asserted mid-instruction SHALL abort that instruction with no write in the reset cycle; the first cycle after deassertion SHALL be FETCH.

Structure
REQ-030 Package rv_ctrl_pkg SHALL hold the state enum, opcode constants, ImmSrc codes, ALUOp codes and ALUControl codes.
REQ-031 ALU decoding SHALL be a separate combinational sub-module, alu_decoder.

Verification
REQ-032 lw (op=0000011): the state sequence SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in MEMWB; ImmSrc=000.
REQ-033 sw (op=0100011): MemWrite=1 exactly one cycle, in MEMWRITE; ImmSrc=001; RegWrite never asserted.
REQ-034 beq funct3=000 with zero=1 -> PCWrite=1 in BRANCH; with zero=0 -> PCWrite=0; bne (funct3=001) with zero=0 -> PCWrite=1; ImmSrc=010.
REQ-035 R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER; addi with funct7b5=1 (op[5]=0) -> ALUControl=000.
REQ-036 op=1111111 -> illegal=1 for one cycle in DECODE, then FETCH; no enables asserted.
REQ-037 Reset asserted in MEMREAD -> no RegWrite; after deassertion, state_dbg=FETCH in the first cycle.
